// File: rtl/pc_sequencer.sv
// Fetch/execute controller driving the PC's 2-bit choice input.
// Sequences imem fetches with req/ack, holds the PC while execute is busy and advances it on retire.
module pc_sequencer #(
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [1:0]         pc_choice,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               halt_req,
    input  logic               resume,
    input  logic               restart,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   retired_count
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [1:0] PC_ADVANCE = 2'b00;
    localparam logic [1:0] PC_BUSY    = 2'b01;
    localparam logic [1:0] PC_STOP    = 2'b10;
    localparam logic [1:0] PC_CLEAR   = 2'b11;

    // Value the counter holds during the last FETCH cycle before timing out.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t             state_reg;
    logic [7:0]         tmo_cnt_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [CNT_W-1:0]   retired_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_BOOT;
            tmo_cnt_reg <= 8'd0;
            instr_reg   <= '0;
            retired_reg <= '0;
        end else if (restart) begin
            // Soft restart keeps the instruction latch and the retire count.
            state_reg   <= S_BOOT;
            tmo_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                S_BOOT: begin
                    state_reg <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_reg   <= imem_data;
                        tmo_cnt_reg <= 8'd0;
                        state_reg   <= S_EXEC;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        tmo_cnt_reg <= 8'd0;
                        state_reg   <= S_FAULT;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        retired_reg <= retired_reg + CNT_W'(1);
                        state_reg   <= halt_req ? S_HALT : S_FETCH;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        state_reg <= S_FETCH;
                    end
                end
                S_FAULT: begin
                    state_reg <= S_FAULT;
                end
                default: begin
                    state_reg <= S_BOOT;
                end
            endcase
        end
    end

    // Outputs follow state and live inputs so the PC acts on them at the same edge.
    always_comb begin
        pc_choice   = PC_BUSY;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (state_reg)
            S_BOOT: begin
                pc_choice = PC_CLEAR;
            end
            S_FETCH: begin
                pc_choice = PC_BUSY;
                imem_req  = 1'b1;
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                pc_choice   = exec_done ? PC_ADVANCE : PC_BUSY;
            end
            S_HALT: begin
                pc_choice = PC_STOP;
                halted    = 1'b1;
            end
            S_FAULT: begin
                pc_choice = PC_STOP;
                fault     = 1'b1;
            end
            default: begin
                pc_choice = PC_CLEAR;
            end
        endcase
        if (restart) begin
            pc_choice = PC_CLEAR;
        end
    end

    assign instr         = instr_reg;
    assign retired_count = retired_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: fetched words go into a scoreboard queue
// and are checked against instr when the DUT enters EXEC.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  pc_choice;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        halt_req;
    logic        resume;
    logic        restart;
    logic        halted;
    logic        fault;
    logic [31:0] retired_count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] instr_q[$];
    logic [31:0] exp_cnt = 32'd0;
    logic [31:0] exp_pc  = 32'd0;
    logic [31:0] pc_model;
    logic [31:0] last_word;

    pc_sequencer #(
        .INSTR_W(32),
        .TIMEOUT(15),
        .CNT_W  (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_choice    (pc_choice),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .halt_req     (halt_req),
        .resume       (resume),
        .restart      (restart),
        .halted       (halted),
        .fault        (fault),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter model driven by pc_choice.
    always_ff @(posedge clk) begin
        case (pc_choice)
            2'b00:   pc_model <= pc_model + 32'd1;
            2'b11:   pc_model <= 32'd0;
            default: pc_model <= pc_model;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each cycle slot starts 1 time unit after the rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Called in a FETCH cycle with the timeout counter at zero.
    task automatic do_fetch(input logic [31:0] data, input int waits);
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                imem_ack  = 1'b1;
                imem_data = data;
                instr_q.push_back(data);
            end
            #1;
            chk("fetch_pc", 64'(pc_choice), 64'(2'b01));
            chk("fetch_req", 64'(imem_req), 64'(1));
            chk("fetch_fault", 64'(fault), 64'(0));
            next();
            imem_ack  = 1'b0;
            imem_data = $urandom;
        end
    endtask

    // Called in the first EXEC cycle; exec_done is raised after busy cycles.
    task automatic do_exec(input int busy, input bit halt, input bit rst_on_done);
        logic [31:0] exp_word;
        for (int i = 0; i <= busy; i++) begin
            if (i == busy) begin
                exec_done = 1'b1;
                halt_req  = halt;
                restart   = rst_on_done;
            end
            #1;
            chk("exec_valid", 64'(instr_valid), 64'(1));
            if (i == 0) begin
                chk("req_drop", 64'(imem_req), 64'(0));
                if (instr_q.size() == 0) begin
                    chk("sb_empty", 64'(1), 64'(0));
                end else begin
                    exp_word = instr_q.pop_front();
                    chk("instr", 64'(instr), 64'(exp_word));
                end
            end
            if (i == busy)
                chk("exec_pc_done", 64'(pc_choice), rst_on_done ? 64'(2'b11) : 64'(2'b00));
            else
                chk("exec_pc_busy", 64'(pc_choice), 64'(2'b01));
            next();
            exec_done = 1'b0;
            halt_req  = 1'b0;
            restart   = 1'b0;
        end
        if (!rst_on_done) begin
            exp_cnt = exp_cnt + 32'd1;
            exp_pc  = exp_pc + 32'd1;
        end
        chk("retired", 64'(retired_count), 64'(exp_cnt));
        $display("txn: instr=%08h retired_count=%0d restart=%0b halt=%0b", instr, retired_count, rst_on_done, halt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 32'd0;
        exec_done = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        restart   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        #1;
        chk("rst_pc", 64'(pc_choice), 64'(2'b11));
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_valid", 64'(instr_valid), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_fault", 64'(fault), 64'(0));
        chk("rst_instr", 64'(instr), 64'(0));
        chk("rst_count", 64'(retired_count), 64'(0));
        next();
        reset = 1'b1;
        #1;
        chk("boot_pc", 64'(pc_choice), 64'(2'b11));
        chk("boot_req", 64'(imem_req), 64'(0));
        next();

        // 1: four instructions, ack after 2 wait cycles, done on 3rd exec cycle
        for (int k = 0; k < 4; k++) begin
            do_fetch(32'h1000_0000 + 32'(k), 2);
            do_exec(2, 1'b0, 1'b0);
        end
        chk("pc_after4", 64'(pc_model), 64'(32'd4));
        chk("count_after4", 64'(retired_count), 64'(32'd4));

        // ack on the last cycle before timeout must win
        do_fetch(32'h0BAD_F00D, 14);
        do_exec(0, 1'b0, 1'b0);

        // 2: ack in first FETCH cycle
        do_fetch(32'hDEAD_BEEF, 0);
        do_exec(1, 1'b0, 1'b0);

        // 3: halt on retire, hold, resume
        do_fetch(32'h1234_5678, 1);
        do_exec(1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("halt_halted", 64'(halted), 64'(1));
            chk("halt_pc", 64'(pc_choice), 64'(2'b10));
            chk("halt_req", 64'(imem_req), 64'(0));
            next();
        end
        chk("halt_pcmodel", 64'(pc_model), 64'(exp_pc));
        resume = 1'b1;
        #1;
        chk("resume_pc", 64'(pc_choice), 64'(2'b10));
        next();
        resume = 1'b0;
        #1;
        chk("resume_req", 64'(imem_req), 64'(1));
        chk("resume_halted", 64'(halted), 64'(0));

        // 4: fetch timeout into FAULT
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("tmo_req", 64'(imem_req), 64'(1));
            chk("tmo_fault", 64'(fault), 64'(0));
            next();
        end
        #1;
        chk("fault_flag", 64'(fault), 64'(1));
        chk("fault_req", 64'(imem_req), 64'(0));
        chk("fault_pc", 64'(pc_choice), 64'(2'b10));
        resume = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next();
            #1;
            chk("fault_resume", 64'(fault), 64'(1));
        end
        resume  = 1'b0;
        restart = 1'b1;
        #1;
        chk("restart_pc", 64'(pc_choice), 64'(2'b11));
        next();
        restart = 1'b0;
        #1;
        chk("reboot_pc", 64'(pc_choice), 64'(2'b11));
        chk("reboot_fault", 64'(fault), 64'(0));
        next();
        #1;
        chk("refetch_req", 64'(imem_req), 64'(1));
        exp_pc = 32'd0;
        chk("restart_pcmodel", 64'(pc_model), 64'(exp_pc));
        chk("restart_count", 64'(retired_count), 64'(exp_cnt));

        // 5: restart on the same cycle as exec_done
        last_word = 32'hA5A5_5A5A;
        do_fetch(last_word, 1);
        do_exec(1, 1'b0, 1'b1);
        #1;
        chk("r5_boot_pc", 64'(pc_choice), 64'(2'b11));
        chk("r5_instr", 64'(instr), 64'(last_word));
        exp_pc = 32'd0;
        next();
        do_fetch(32'hC0DE_0001, 0);
        do_exec(0, 1'b0, 1'b0);
        chk("r5_pcmodel", 64'(pc_model), 64'(exp_pc));

        // 6: asynchronous reset mid-EXEC, then mid-FETCH
        do_fetch(32'h7777_0000, 1);
        instr_q.delete();
        #1;
        chk("pre_rst_valid", 64'(instr_valid), 64'(1));
        reset = 1'b0;
        #1;
        chk("arst_pc", 64'(pc_choice), 64'(2'b11));
        chk("arst_valid", 64'(instr_valid), 64'(0));
        chk("arst_count", 64'(retired_count), 64'(0));
        chk("arst_instr", 64'(instr), 64'(0));
        next();
        reset = 1'b1;
        #1;
        chk("arst_boot_pc", 64'(pc_choice), 64'(2'b11));
        next();
        #1;
        chk("arst_fetch_req", 64'(imem_req), 64'(1));
        reset = 1'b0;
        #1;
        chk("arst_req_drop", 64'(imem_req), 64'(0));
        next();
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
